// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   funct3_e   : RV32I load/store width encodings
//   state_e    : access sequencer states
//   size_mask  : byte mask (LSB-justified) covered by an access of a given funct3
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_WAIT,
        ST_ACC2,
        ST_WAIT2,
        ST_RESP
    } state_e;

    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            3'b000, 3'b100: size_mask = 4'b0001;
            3'b001, 3'b101: size_mask = 4'b0011;
            3'b010:         size_mask = 4'b1111;
            default:        size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shifts a 64-bit {hi,lo} read window right by the byte
// offset, then sign- or zero-extends according to funct3.
// Ports:
//   win     in  64  read window {second word, first word}
//   off     in  2   byte offset of the access inside the first word
//   funct3  in  3   load width/extension selector
//   data    out 32  extended load result (0 for non-load encodings)
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] win,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = 32'(win >> {off, 3'b000});
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    data = shifted;
            F3_BU:   data = {24'h000000, shifted[7:0]};
            F3_HU:   data = {16'h0000, shifted[15:0]};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: initiator side of the data-memory port. Accepts one request
// at a time, drives word address / lane strobes / lane-positioned write data,
// and returns a single-cycle response with extended load data or an error.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (misaligned accesses allowed,
// word-crossing ones split into two memory accesses).
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   req_valid/req_ready                request handshake
//   req_we, req_funct3, req_addr, req_wdata   request fields
//   rsp_valid, rsp_rdata, rsp_err      one-cycle response
//   mem_re, mem_wstrb, mem_a, mem_wd   memory request side
//   mem_rd                             memory read data
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_ACC   | access to first word (strobes/re asserted)
// ST_WAIT  | registered-memory read of first word in flight
// ST_ACC2  | access to second word of a word-crossing access
// ST_WAIT2 | registered-memory read of second word in flight
// ST_RESP  | response pulse
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_re,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam bit REG_READ = (READ_LATENCY != 0);

    state_e      state, state_nxt;
    logic        op_we, op_err, op_cross;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr, op_wdata;
    logic [31:0] rd_lo, rd_hi, ld_data, word_a;
    logic [7:0]  op_strb;
    logic [63:0] op_wd;
    logic        req_legal, req_misalign, req_cross, req_err;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [7:0]  req_strb;
`endif

    always_comb begin
        if (req_we) req_legal = req_funct3 inside {F3_B, F3_H, F3_W};
        else        req_legal = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
`ifdef LSU_MISALIGN_SPLIT_EN
        // Any strobe spilling past lane 3 means the access touches the next word.
        req_strb     = {4'b0000, size_mask(req_funct3)} << req_addr[1:0];
        req_misalign = 1'b0;
        req_cross    = req_legal && (|req_strb[7:4]);
`else
        req_misalign = ((req_funct3 inside {F3_H, F3_HU}) && req_addr[0]) ||
                       ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
        req_cross    = 1'b0;
`endif
        req_err = !req_legal || req_misalign;
    end

    // 64-bit lane images of the captured request; low half goes out in ACC, high in ACC2.
    assign op_strb = {4'b0000, size_mask(op_funct3)} << op_addr[1:0];
    assign op_wd   = {32'h0000_0000, op_wdata} << {op_addr[1:0], 3'b000};
    assign word_a  = {op_addr[31:2], 2'b00};

    lsu_load_align u_align (
        .win    ({rd_hi, rd_lo}),
        .off    (op_addr[1:0]),
        .funct3 (op_funct3),
        .data   (ld_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            op_we     <= 1'b0;
            op_err    <= 1'b0;
            op_cross  <= 1'b0;
            op_funct3 <= 3'b000;
            op_addr   <= 32'h0000_0000;
            op_wdata  <= 32'h0000_0000;
            rd_lo     <= 32'h0000_0000;
            rd_hi     <= 32'h0000_0000;
        end else begin
            state <= state_nxt;
            if (req_valid && req_ready) begin
                op_we     <= req_we;
                op_err    <= req_err;
                op_cross  <= req_cross;
                op_funct3 <= req_funct3;
                op_addr   <= req_addr;
                op_wdata  <= req_wdata;
            end
            // Read data is valid in the access cycle for combinational memory,
            // one cycle later (WAIT) for registered memory.
            if (!op_we && ((state == ST_ACC && !REG_READ) || state == ST_WAIT))
                rd_lo <= mem_rd;
            if (!op_we && ((state == ST_ACC2 && !REG_READ) || state == ST_WAIT2))
                rd_hi <= mem_rd;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0000_0000;
        rsp_err   = 1'b0;
        mem_re    = 1'b0;
        mem_wstrb = 4'b0000;
        mem_a     = 32'h0000_0000;
        mem_wd    = 32'h0000_0000;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_err ? ST_RESP : ST_ACC;
            end
            ST_ACC: begin
                mem_a     = word_a;
                mem_re    = !op_we;
                mem_wstrb = op_we ? op_strb[3:0] : 4'b0000;
                mem_wd    = op_we ? op_wd[31:0] : 32'h0000_0000;
                if (!op_we && REG_READ) state_nxt = ST_WAIT;
                else if (op_cross)      state_nxt = ST_ACC2;
                else                    state_nxt = ST_RESP;
            end
            ST_WAIT: begin
                mem_a     = word_a;
                state_nxt = op_cross ? ST_ACC2 : ST_RESP;
            end
            ST_ACC2: begin
                mem_a     = word_a + 32'd4;
                mem_re    = !op_we;
                mem_wstrb = op_we ? op_strb[7:4] : 4'b0000;
                mem_wd    = op_we ? op_wd[63:32] : 32'h0000_0000;
                state_nxt = (!op_we && REG_READ) ? ST_WAIT2 : ST_RESP;
            end
            ST_WAIT2: begin
                mem_a     = word_a + 32'd4;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = op_err;
                rsp_rdata = (op_err || op_we) ? 32'h0000_0000 : ld_data;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
